// File: rtl/adder_bist_pkg.sv
// Shared defaults, FSM state encoding and the stored-pattern layout for the
// adder BIST controller.
package adder_bist_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N          = 9;
  localparam int DEF_LATENCY    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // One memory entry: operands a, b and the expected sum y (mod 2^width).
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] a;
    logic [DEF_DATA_WIDTH-1:0] b;
    logic [DEF_DATA_WIDTH-1:0] y;
  } pattern_t;

endpackage

// File: rtl/adder_bist_mem.sv
// Pattern store: one synchronous write port, an operand read port for the
// issue side and a golden-result read port for the compare side.
module adder_bist_mem
  import adder_bist_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int AW         = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]           iss_addr,
  output logic [2*DATA_WIDTH-1:0] iss_ab,
  input  logic [AW-1:0]           cmp_addr,
  output logic [DATA_WIDTH-1:0]   cmp_y
);

  logic [3*DATA_WIDTH-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-through on the issue port so a load in the start cycle reaches entry 0.
  assign iss_ab = (we && (waddr == iss_addr)) ? wdata[3*DATA_WIDTH-1:DATA_WIDTH]
                                              : mem[iss_addr][3*DATA_WIDTH-1:DATA_WIDTH];
  assign cmp_y  = mem[cmp_addr][DATA_WIDTH-1:0];

endmodule

// File: rtl/adder_bist.sv
// BIST controller for a pipelined adder: streams stored operand pairs to the
// DUT one per cycle and checks each result against its stored golden sum.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [$clog2(N)-1:0]      load_addr,
  input  logic [3*DATA_WIDTH-1:0]   load_data,
  input  logic                      start,
  output logic [DATA_WIDTH-1:0]     a0,
  output logic [DATA_WIDTH-1:0]     a1,
  input  logic [DATA_WIDTH-1:0]     y,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [$clog2(N+1)-1:0]    err_cnt,
  output logic [$clog2(N)-1:0]      first_err_idx
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N+1);

  state_t                  state, state_nxt;
  logic [CW-1:0]           iss_idx;
  logic [AW-1:0]           iss_addr;
  logic [2*DATA_WIDTH-1:0] iss_ab;
  logic [DATA_WIDTH-1:0]   cmp_y;
  logic                    vld_p [LATENCY+1];
  logic [AW-1:0]           idx_p [LATENCY+1];
  logic                    idle_like, start_ok, mem_we, issue, iss_more;
  logic                    cmp_vld, cmp_last, mismatch;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign start_ok  = start && idle_like;
  assign mem_we    = load_en && idle_like && (int'(load_addr) < N);
  assign iss_more  = int'(iss_idx) < N;
  assign iss_addr  = (state == ST_DRIVE) ? iss_idx[AW-1:0] : '0;
  assign issue     = start_ok || ((state == ST_DRIVE) && iss_more);

  assign cmp_vld   = vld_p[LATENCY];
  assign cmp_last  = cmp_vld && (int'(idx_p[LATENCY]) == N - 1);
  assign mismatch  = cmp_vld && (y != cmp_y);

  assign busy = (state == ST_DRIVE) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == '0);

  adder_bist_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .AW         (AW)
  ) u_mem (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (load_addr),
    .wdata    (load_data),
    .iss_addr (iss_addr),
    .iss_ab   (iss_ab),
    .cmp_addr (idx_p[LATENCY]),
    .cmp_y    (cmp_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        if (cmp_last)       state_nxt = ST_DONE;
        else if (!iss_more) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (cmp_last) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_DRIVE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: operand issue register; p1..pLATENCY: compare-side valid/index delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      a0            <= '0;
      a1            <= '0;
      iss_idx       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      for (int k = 0; k <= LATENCY; k++) vld_p[k] <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        a0       <= iss_ab[2*DATA_WIDTH-1:DATA_WIDTH];
        a1       <= iss_ab[DATA_WIDTH-1:0];
        vld_p[0] <= 1'b1;
        iss_idx  <= start_ok ? CW'(1) : iss_idx + CW'(1);
      end else begin
        a0       <= '0;
        a1       <= '0;
        vld_p[0] <= 1'b0;
      end
      for (int k = 1; k <= LATENCY; k++) vld_p[k] <= vld_p[k-1];
      if (start_ok) begin
        err_cnt       <= '0;
        first_err_idx <= '0;
      end else if (mismatch) begin
        err_cnt <= err_cnt + CW'(1);
        if (err_cnt == '0) first_err_idx <= idx_p[LATENCY];
      end
    end
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= iss_addr;
    for (int k = 1; k <= LATENCY; k++) idx_p[k] <= idx_p[k-1];
  end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a behavioural pipelined adder as the unit under test,
// a pattern-memory model and per-cycle checks of the run timeline.
module tb_adder_bist;
  import adder_bist_pkg::*;

  localparam int DW  = 16;
  localparam int N   = 9;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [3:0]    load_addr = '0;
  logic [47:0]   load_data = '0;
  logic          start = 1'b0;
  logic [DW-1:0] a0, a1, y;
  logic          busy, done, pass;
  logic [3:0]    err_cnt;
  logic [3:0]    first_err_idx;

  int checks = 0;
  int failures = 0;

  logic [47:0]   mdl [N];
  logic [DW-1:0] ypipe [LAT];

  always #5 clk = ~clk;

  adder_bist #(.DATA_WIDTH(DW), .N(N), .LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .start         (start),
    .a0            (a0),
    .a1            (a1),
    .y             (y),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx)
  );

  // Adder under test: sum appears LAT cycles after its operands.
  always @(posedge clk) begin
    ypipe[0] <= a0 + a1;
    for (int k = 1; k < LAT; k++) ypipe[k] <= ypipe[k-1];
  end
  assign y = ypipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [15:0] a, input logic [15:0] b);
    pattern_t p;
    p.a = a;
    p.b = b;
    p.y = a + b;
    return p;
  endfunction

  // Called at a negedge while the controller is idle or done.
  task automatic load(input int addr, input logic [47:0] data);
    load_en   = 1'b1;
    load_addr = 4'(addr);
    load_data = data;
    if (addr < N) mdl[addr] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Starts a run at the next edge E(0) and checks outputs after every edge.
  task automatic run_bist(input int s0, input int s1, input int mid_c, input int rst_c,
                          input bit co_load, input logic [47:0] co_data);
    logic [47:0] snap [N];
    pattern_t    p;
    int          exp_err, exp_first;
    bit          fin;
    if (co_load) begin
      load_en   = 1'b1;
      load_addr = 4'd0;
      load_data = co_data;
      mdl[0]    = co_data;
    end
    exp_err = 0;
    exp_first = 0;
    for (int i = 0; i < N; i++) begin
      snap[i] = mdl[i];
      p = mdl[i];
      if (p.y !== 16'(p.a + p.b)) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
    end
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    load_en = 1'b0;
    for (int c = 0; c <= N + LAT + 1; c++) begin
      if (c == rst_c) begin
        check($sformatf("rst_a0@%0d", c), a0, 0);
        check($sformatf("rst_a1@%0d", c), a1, 0);
        check($sformatf("rst_busy@%0d", c), busy, 0);
        check($sformatf("rst_done@%0d", c), done, 0);
        check($sformatf("rst_pass@%0d", c), pass, 0);
        check($sformatf("rst_err@%0d", c), err_cnt, 0);
        check($sformatf("rst_first@%0d", c), first_err_idx, 0);
        rst = 1'b0;
        break;
      end
      p = snap[(c < N) ? c : 0];
      check($sformatf("a0@%0d", c), a0, (c < N) ? p.a : 16'h0);
      check($sformatf("a1@%0d", c), a1, (c < N) ? p.b : 16'h0);
      check($sformatf("busy@%0d", c), busy, (c < N + LAT) ? 1 : 0);
      fin = (c >= N + LAT);
      check($sformatf("done@%0d", c), done, fin);
      if (fin) begin
        check($sformatf("err_cnt@%0d", c), err_cnt, exp_err);
        check($sformatf("first_idx@%0d", c), first_err_idx, exp_first);
        check($sformatf("pass@%0d", c), pass, (exp_err == 0) ? 1 : 0);
      end
      start = (c + 1 == s0) || (c + 1 == s1);
      if (c + 1 == mid_c) begin
        load_en   = 1'b1;
        load_addr = 4'd2;
        load_data = {16'h1234, 16'h1111, 16'h0000};
      end else begin
        load_en = 1'b0;
      end
      if (c + 1 == rst_c) rst = 1'b1;
      @(negedge clk);
    end
    start   = 1'b0;
    load_en = 1'b0;
  endtask

  initial begin
    pattern_t p;
    @(negedge clk);
    @(negedge clk);
    check("reset_a0", a0, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_err", err_cnt, 0);
    check("reset_first", first_err_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    load(0, {16'h0001, 16'h0002, 16'h0003});
    load(1, {16'hFFFF, 16'h0001, 16'h0000});
    for (int i = 2; i < N; i++) load(i, mk(16'($urandom), 16'($urandom)));
    run_bist(-1, -1, -1, -1, 1'b0, '0);
    check("basic_pass", pass, 1);

    run_bist(3, 5, -1, -1, 1'b0, '0);

    p = mdl[4]; p.y = p.y + 16'd1; load(4, p);
    p = mdl[7]; p.y = p.y ^ 16'($urandom_range(1, 65535)); load(7, p);
    run_bist(-1, -1, -1, -1, 1'b0, '0);
    check("two_err_cnt", err_cnt, 2);
    check("two_err_first", first_err_idx, 4);
    p = mdl[4]; load(4, mk(p.a, p.b));
    p = mdl[7]; load(7, mk(p.a, p.b));

    run_bist(-1, -1, -1, 6, 1'b0, '0);
    run_bist(-1, -1, -1, -1, 1'b0, '0);
    check("after_rst_pass", pass, 1);

    run_bist(-1, -1, 3, -1, 1'b0, '0);
    check("busy_load_ignored", pass, 1);
    load(2, {16'h1234, 16'h1111, 16'h0000});
    run_bist(-1, -1, -1, -1, 1'b0, '0);
    check("done_load_first", first_err_idx, 2);
    p = mdl[2]; load(2, mk(p.a, p.b));

    run_bist(-1, -1, -1, -1, 1'b1, {16'h0010, 16'h0020, 16'h0031});
    check("coload_first", first_err_idx, 0);
    run_bist(-1, -1, -1, -1, 1'b1, mk(16'h0010, 16'h0020));
    check("coload_fix_pass", pass, 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        p = mk(16'($urandom), 16'($urandom));
        if ($urandom_range(0, 3) == 0) p.y = p.y ^ 16'($urandom_range(1, 65535));
        load(i, p);
      end
      load(N + int'($urandom_range(0, 15 - N)), {16'hDEAD, 16'hBEEF, 16'h0BAD});
      run_bist(-1, -1, -1, -1, 1'b0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 16, operand/result width.
REQ-002 The block SHALL expose parameter N, default 9, number of stored patterns.
REQ-003 The block SHALL expose parameter LATENCY, default 2, DUT input-to-output cycles.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_en  input  1  write one pattern entry this cycle.
REQ-007 load_addr  input  clog2(N)  entry index.
REQ-008 load_data  input  3*DATA_WIDTH  {A[47:32], B[31:16], golden Y[15:0]}.
REQ-009 start  input  1  single-cycle run request.
REQ-010 a0, a1  output  DATA_WIDTH each  operands to DUT, registered.
REQ-011 y  input  DATA_WIDTH  DUT result.
REQ-012 busy  output  1  run in progress.
REQ-013 done  output  1  run complete, results valid.
REQ-014 pass  output  1  done with zero errors.
REQ-015 err_cnt  output  clog2(N+1)  mismatches in last run.
REQ-016 first_err_idx  output  clog2(N)  index of first mismatch; 0 if none.

Function
REQ-017 FSM states IDLE, DRIVE, DRAIN, DONE only.
- IDLE -> DRIVE on start; DRIVE -> DRAIN after pattern N-1 issued; DRAIN -> DONE after last compare; DONE -> DRIVE on start.
REQ-018 Pattern i SHALL appear on a0/a1 in the cycle following edge E(i), where E(0) is the edge sampling start; one pattern per cycle, no gaps.
REQ-019 y for pattern i SHALL be compared against golden Y(i) at edge E(i+LATENCY+1), using a LATENCY-deep valid/index pipeline.
REQ-020 Comparison SHALL be exact bitwise, full DATA_WIDTH; golden Y is modulo 2^DATA_WIDTH.
REQ-021 Each mismatch SHALL increment err_cnt; first mismatch SHALL latch first_err_idx; later mismatches leave it unchanged.
REQ-022 done SHALL rise at edge E(N+LATENCY) (edge 11 for defaults) and hold until next start or rst.
REQ-023 pass SHALL equal done AND (err_cnt==0).
REQ-024 busy SHALL be high exactly in DRIVE and DRAIN.
REQ-025 a0/a1 SHALL be 0 outside DRIVE.
REQ-026 start while busy SHALL be ignored.
REQ-027 load_en while busy SHALL be ignored; in IDLE/DONE it writes entry load_addr at the edge; load_addr >= N ignored.
REQ-028 start from DONE SHALL clear err_cnt, first_err_idx, done, pass at that edge and begin a new run.
REQ-029 load_en and start in the same IDLE cycle: write takes effect; the run uses the new data only if the entry is read after that edge (entry 0 is read at E(0), so it SHALL use the new value).

Reset
REQ-030 rst SHALL force IDLE and drive a0, a1, busy, done, pass, err_cnt, first_err_idx to 0 at the next edge, including mid-DRIVE/DRAIN.
REQ-031 rst SHALL NOT clear pattern memory contents; in-flight compares SHALL be discarded.

Structure
REQ-032 Package adder_bist_pkg SHALL hold DATA_WIDTH/N/LATENCY defaults, the FSM state enum, and the pattern struct {a, b, y}.
REQ-033 Pattern storage SHALL be sub-module adder_bist_mem (1 write port, 2 read ports: issue index, compare index).

Verification
REQ-034 Load {0001,0002,0003},{FFFF,0001,0000},7 more correct; start -> busy 11 cycles, done at edge 11, pass=1, err_cnt=0.
REQ-035 Corrupt entry 4 golden Y (+1) and entry 7 -> err_cnt=2, first_err_idx=4, pass=0.
REQ-036 Pulse start at edges 3 and 5 of a run -> identical timing/results to REQ-034, no restart.
REQ-037 Assert rst at edge 6 of a run -> next cycle all outputs 0, IDLE; new start reruns from index 0 with stored patterns, pass=1.
REQ-038 load_en during DRIVE to entry 2 with bad golden -> ignored; run passes; same load in DONE then start -> err_cnt=1, first_err_idx=2.
